// File: rtl/rs_latch_driver_pkg.sv
// Shared types and default timing constants for the RS latch driver.
// Op encoding matches the value the latch's Q takes after the pulse.
package rs_latch_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_GAP
  } state_e;

  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_e;

  localparam int DEF_DEB_CYCLES = 16;
  localparam int DEF_PULSE_LEN  = 4;
  localparam int DEF_GAP_LEN    = 2;
  localparam int DEF_CNT_W      = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rs_latch_driver_sync_debounce.sv
// Two-flop synchroniser, stable-sample debouncer and rising-edge pulse
// for one raw switch input.
module sync_debounce
  import rs_latch_driver_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out
);

  localparam int CW = $clog2(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced sample disagrees with the level.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;

endmodule

// File: rtl/rs_latch_driver.sv
// Gated RS latch driver: debounced set/clear requests become a single
// clean S or R pulse framed by the gate, with a model of the latch Q.
module rs_latch_driver
  import rs_latch_driver_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_LEN  = DEF_PULSE_LEN,
  parameter int GAP_LEN    = DEF_GAP_LEN,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_req,
  input  logic             clr_req,
  output logic             s_out,
  output logic             r_out,
  output logic             gate_out,
  output logic             q_model,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam int TW = $clog2(max_int(PULSE_LEN, GAP_LEN) + 1);

  logic [1:0] raw_w, level_w, rise_w;
  logic       set_rise, clr_rise;

  assign raw_w = {clr_req, set_req};

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_in    (raw_w[gi]),
      .level_out (level_w[gi]),
      .rise_out  (rise_w[gi])
    );
  end

  assign set_rise = rise_w[0] & level_w[0];
  assign clr_rise = rise_w[1] & level_w[1];

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             s_q, s_d, r_q, r_d, gate_q, gate_d;
  logic             q_model_q, q_model_d, busy_q, busy_d;
  logic [CNT_W-1:0] conflict_q, conflict_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    timer_d    = timer_q;
    q_model_d  = q_model_q;
    conflict_d = conflict_q;
    case (state_q)
      ST_IDLE: begin
        if (set_rise && clr_rise) begin
          if (conflict_q != '1) conflict_d = conflict_q + 1'b1;
        end else if (set_rise) begin
          op_d    = OP_SET;
          state_d = ST_SETUP;
        end else if (clr_rise) begin
          op_d    = OP_CLR;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_PULSE;
        timer_d = TW'(PULSE_LEN - 1);
      end
      ST_PULSE: begin
        if (timer_q == '0) begin
          state_d   = ST_HOLD;
          q_model_d = (op_q == OP_SET);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_HOLD: begin
        state_d = ST_GAP;
        timer_d = TW'(GAP_LEN - 1);
      end
      ST_GAP: begin
        if (timer_q == '0) state_d = ST_IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Drives are decoded from the next state so they come straight off flops.
    gate_d = (state_d == ST_SETUP) || (state_d == ST_PULSE) || (state_d == ST_HOLD);
    s_d    = (state_d == ST_PULSE) && (op_d == OP_SET);
    r_d    = (state_d == ST_PULSE) && (op_d == OP_CLR);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_CLR;
      timer_q    <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      gate_q     <= 1'b0;
      q_model_q  <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      timer_q    <= timer_d;
      s_q        <= s_d;
      r_q        <= r_d;
      gate_q     <= gate_d;
      q_model_q  <= q_model_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign s_out        = s_q;
  assign r_out        = r_q;
  assign gate_out     = gate_q;
  assign q_model      = q_model_q;
  assign busy         = busy_q;
  assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_rs_latch_driver.sv
// Scoreboard bench: stimulus queues expected pulses / conflict counts,
// a negedge monitor pops and compares them and checks drive invariants.
module tb_rs_latch_driver;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             set_req = 1'b0;
  logic             clr_req = 1'b0;
  logic             s_out, r_out, gate_out, q_model, busy;
  logic [CNT_W-1:0] conflict_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic op;
    int   len;
    logic q;
  } pulse_t;

  pulse_t           pq[$];
  logic [CNT_W-1:0] cq[$];

  always #5 clk = ~clk;

  rs_latch_driver #(
    .DEB_CYCLES (16),
    .PULSE_LEN  (4),
    .GAP_LEN    (2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_req      (set_req),
    .clr_req      (clr_req),
    .s_out        (s_out),
    .r_out        (r_out),
    .gate_out     (gate_out),
    .q_model      (q_model),
    .busy         (busy),
    .conflict_cnt (conflict_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor
  logic             in_pulse = 1'b0;
  logic             run_op = 1'b0;
  logic             prev_gate = 1'b0;
  logic             post_hold = 1'b0;
  int               run_len = 0;
  logic [CNT_W-1:0] prev_cc = '0;
  pulse_t           e;
  logic [CNT_W-1:0] ce;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_pulse  = 1'b0;
      run_len   = 0;
      prev_gate = 1'b0;
      post_hold = 1'b0;
      prev_cc   = '0;
    end else begin
      chk("s_and_r_together", s_out & r_out, 0);
      chk("sr_without_gate", (s_out | r_out) & ~gate_out, 0);
      if (s_out | r_out) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          run_len  = 0;
          run_op   = s_out;
          chk("gate_before_pulse", prev_gate, 1);
        end
        run_len++;
      end else if (in_pulse) begin
        in_pulse  = 1'b0;
        post_hold = 1'b1;
        if (pq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pulse: got op=%0d len=%0d, expected no pulse", run_op, run_len);
        end else begin
          e = pq.pop_front();
          $display("pulse op=%s len=%0d q_model=%0d", run_op ? "SET" : "CLR", run_len, q_model);
          chk("pulse_op", run_op, e.op);
          chk("pulse_len", run_len, e.len);
          chk("gate_in_hold", gate_out, 1);
          chk("q_model_after_pulse", q_model, e.q);
        end
      end else if (post_hold) begin
        post_hold = 1'b0;
        chk("gate_after_hold", gate_out, 0);
      end
      prev_gate = gate_out;

      if (conflict_cnt != prev_cc) begin
        if (cq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_conflict_change: got %0d, expected %0d", conflict_cnt, prev_cc);
        end else begin
          ce = cq.pop_front();
          $display("conflict_cnt=%0d", conflict_cnt);
          chk("conflict_cnt", conflict_cnt, ce);
        end
        prev_cc = conflict_cnt;
      end
    end
  end

  // Stimulus
  logic [CNT_W-1:0] exp_cc = '0;
  int               k = 0;

  initial begin
    // 1: reset state, then a clean set
    @(negedge clk);
    chk("rst_s_out", s_out, 0);
    chk("rst_r_out", r_out, 0);
    chk("rst_gate_out", gate_out, 0);
    chk("rst_q_model", q_model, 0);
    chk("rst_busy", busy, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(3);

    pq.push_back('{1'b1, 4, 1'b1});
    set_req = 1'b1;
    cycles(50);
    @(negedge clk);
    chk("t1_idle_after", busy, 0);
    chk("t1_q_model", q_model, 1);
    cycles(1);
    set_req = 1'b0;
    cycles(30);

    // 2: bouncing input, then stable high
    for (int i = 0; i < 12; i++) begin
      set_req = ~set_req;
      cycles(5);
    end
    pq.push_back('{1'b1, 4, 1'b1});
    set_req = 1'b1;
    cycles(50);
    set_req = 1'b0;
    cycles(30);

    // 6a: clear after the sets
    pq.push_back('{1'b0, 4, 1'b0});
    clr_req = 1'b1;
    cycles(50);
    @(negedge clk);
    chk("t6_q_model_cleared", q_model, 0);
    cycles(1);
    clr_req = 1'b0;
    cycles(30);

    // 4: clear rises during a set pulse and is dropped
    pq.push_back('{1'b1, 4, 1'b1});
    set_req = 1'b1;
    cycles(3);
    clr_req = 1'b1;
    cycles(50);
    @(negedge clk);
    chk("t4_q_model", q_model, 1);
    chk("t4_conflict_unchanged", conflict_cnt, 0);
    cycles(1);
    set_req = 1'b0;
    clr_req = 1'b0;
    cycles(30);

    // 5: reset on the 2nd pulse cycle
    set_req = 1'b1;
    k = 0;
    while (!s_out && k < 80) begin
      @(negedge clk);
      k++;
    end
    chk("t5_pulse_started", s_out, 1);
    chk("t5_q_model_before_reset", q_model, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_s_out_in_reset", s_out, 0);
    chk("t5_gate_in_reset", gate_out, 0);
    chk("t5_busy_in_reset", busy, 0);
    chk("t5_q_model_in_reset", q_model, 0);
    set_req = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    cycles(40);
    @(negedge clk);
    chk("t5_idle_after_release", busy, 0);
    chk("t5_q_model_after_release", q_model, 0);
    cycles(1);
    pq.push_back('{1'b1, 4, 1'b1});
    set_req = 1'b1;
    cycles(50);
    set_req = 1'b0;
    cycles(30);

    // 6b: final clear
    pq.push_back('{1'b0, 4, 1'b0});
    clr_req = 1'b1;
    cycles(50);
    clr_req = 1'b0;
    cycles(30);

    // 3: simultaneous requests saturate the conflict counter
    for (int i = 0; i < 300; i++) begin
      if (exp_cc != '1) begin
        exp_cc = exp_cc + 1'b1;
        cq.push_back(exp_cc);
      end
      set_req = 1'b1;
      clr_req = 1'b1;
      cycles(22);
      set_req = 1'b0;
      clr_req = 1'b0;
      cycles(20);
    end
    @(negedge clk);
    chk("conflict_saturated", conflict_cnt, 255);
    chk("conflict_busy_idle", busy, 0);
    chk("pulse_queue_drained", pq.size(), 0);
    chk("conflict_queue_drained", cq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_latch_driver.md
Name: rs_latch_driver

Overview:
- Drives a gated RS latch from two raw, asynchronous, bouncing switch inputs.
- Synchronises and debounces both request lines, then detects their rising edges.
- Issues one clean, mutually exclusive S or R pulse of programmable width, with the gate (enable) asserted around it.
- Keeps a reference model of the expected latch state so the board-level check can compare it against the latch's Qa.

Parameters:
- DEB_CYCLES, 16, consecutive stable samples required before a debounced level changes (>=2).
- PULSE_LEN, 4, cycles S/R stays high during a pulse (>=1).
- GAP_LEN, 2, idle cycles after a pulse before the next request is accepted (>=1).
- CNT_W, 8, width of the conflict counter.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- set_req, input, 1, raw asynchronous set switch.
- clr_req, input, 1, raw asynchronous reset switch.
- s_out, output, 1, latch S drive.
- r_out, output, 1, latch R drive.
- gate_out, output, 1, latch clock/enable.
- q_model, output, 1, expected latch Q.
- busy, output, 1, high in any state other than IDLE.
- conflict_cnt, output, CNT_W, count of dropped simultaneous requests; saturates at all-ones.

Behaviour:
- Reset: on rst_n low, asynchronously clear every flop.
  - All outputs become 0; FSM goes to IDLE.
  - Synchroniser and debounced levels become 0.
  - Debounce counters become 0.
- Synchroniser: 2-flop synchroniser on each request input.
- Debounce:
  - Each input has a counter that increments while the synced value differs from its debounced level, and clears when they are equal.
  - When the counter reaches DEB_CYCLES-1, the debounced level flips and the counter clears.
- Edge detect: set_rise and clr_rise are single-cycle pulses on a 0->1 transition of the debounced level.
- FSM states: IDLE, SETUP, PULSE, HOLD, GAP.
- IDLE:
  - set_rise only: latch op=SET, go to SETUP.
  - clr_rise only: latch op=CLR, go to SETUP.
  - Both in the same cycle: no pulse, increment conflict_cnt (saturating), stay in IDLE.
- SETUP (1 cycle): gate_out=1, s_out=r_out=0.
- PULSE (PULSE_LEN cycles):
  - gate_out=1; s_out=1 if op=SET, r_out=1 if op=CLR.
  - On the last cycle, q_model takes 1 for SET or 0 for CLR; the value is registered and visible the next cycle.
- HOLD (1 cycle): gate_out=1, s_out=r_out=0. This drops S/R before the gate closes.
- GAP (GAP_LEN cycles): all drives 0, then go to IDLE.
- Invariants:
  - s_out and r_out are never high together.
  - s_out or r_out is high only while gate_out is high.
  - All three are registered outputs, so they are glitch-free.
- Rises outside IDLE are dropped and not queued; conflict_cnt does not change.
- Total cycles from acceptance back to IDLE: PULSE_LEN + GAP_LEN + 2.
- Latency: s_out/r_out first go high 2 cycles after the edge-detect cycle.
- A debounced level falling never causes any action.
- Reset mid-pulse: all drives drop immediately (asynchronously), q_model returns to 0, and the in-flight op is lost.

Decomposition:
- Shared package holds:
  - FSM state enumeration (IDLE, SETUP, PULSE, HOLD, GAP).
  - op encoding (SET=1, CLR=0).
  - Default constants for the timing parameters.
- One sub-module, sync_debounce, instantiated twice. It contains the 2-flop synchroniser, the DEB_CYCLES counter and the rising-edge pulse.
- Its ports are clk, rst_n, raw_in, level_out, rise_out, with parameter DEB_CYCLES.

Test Plan:
1. Reset, then set_req held high with clean edges:
   - Exactly 4 consecutive cycles of s_out=1 with gate_out=1, bracketed by one gate-only cycle on each side.
   - q_model=1 after the pulse; r_out stays 0 throughout.
2. set_req toggling every 5 cycles for 60 cycles, then high (DEB_CYCLES=16):
   - No pulse during the bounce.
   - Exactly one S pulse after 16 stable cycles.
3. set_req and clr_req raised in the same cycle:
   - No s_out/r_out activity; conflict_cnt goes 0->1.
   - Repeated 300 times with CNT_W=8: conflict_cnt saturates at 255.
4. clr_req rises while a SET pulse is in progress (busy=1):
   - The SET pulse completes; the clear is dropped with no later R pulse; q_model=1.
5. rst_n asserted on the 2nd PULSE cycle:
   - s_out, gate_out, busy and q_model are 0 in the same cycle.
   - After release, the FSM is IDLE and no pulse occurs until a fresh debounced rise.
6. Set then clear, spaced more than 30 cycles apart:
   - q_model 0->1->0.
   - A checker on every cycle confirms s_out&r_out never asserts and S/R is never high while gate_out=0.
